// File: rtl/lap_timer_pkg.sv
// Shared types for the lap timer: FSM state encoding and count-direction constants.
package lap_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/lap_fifo.sv
// Synchronous first-word-fall-through circular buffer with occupancy count and clear.
module lap_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && valid;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !(rst || clear))
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lap_timer.sv
// Stopwatch/countdown timer: exact-period tick prescaler, run/pause/done FSM and lap capture buffer.
import lap_timer_pkg::*;

module lap_timer #(
    parameter int CLK_DIV   = 100_000_000,
    parameter int TIME_W    = 32,
    parameter int LAP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           clear,
    input  logic                           mode,
    input  logic                           load,
    input  logic [TIME_W-1:0]              load_value,
    input  logic                           lap,
    input  logic                           lap_rd,
    output logic [TIME_W-1:0]              elapsed,
    output logic                           running,
    output logic                           tick,
    output logic                           expired,
    output logic [TIME_W-1:0]              lap_time,
    output logic                           lap_valid,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_overflow
);

    localparam int PS_W = $clog2(CLK_DIV);

    state_e           state;
    state_e           state_nxt;
    logic [PS_W-1:0]  prescaler;
    logic             mode_q;
    logic             wrap;
    logic             start_ok;
    logic             lap_push;
    logic             lap_full;

    always_comb begin
        wrap     = (prescaler == PS_W'(CLK_DIV - 1));
        // Abort sources and stop take the cycle, so a coincident wrap never ticks.
        tick     = (state == RUN) && wrap && !rst && !clear && !load && !stop;
        expired  = tick && (mode_q == MODE_DOWN) && (elapsed == TIME_W'(1));
        start_ok = start && ((state == IDLE) || (state == PAUSE)) &&
                   !((mode == MODE_DOWN) && (elapsed == '0));
        lap_push = lap && ((state == RUN) || (state == PAUSE)) && !clear;
        running  = (state == RUN);

        state_nxt = state;
        if (clear || load)
            state_nxt = IDLE;
        else if (stop)
            state_nxt = (state == RUN) ? PAUSE : state;
        else if (start_ok)
            state_nxt = RUN;
        else if (expired)
            state_nxt = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prescaler <= '0;
            elapsed   <= '0;
            mode_q    <= MODE_UP;
        end else begin
            state <= state_nxt;
            if (clear) begin
                elapsed   <= '0;
                prescaler <= '0;
            end else if (load) begin
                elapsed   <= load_value;
                prescaler <= '0;
            end else if (stop) begin
                // Pause keeps the prescaler so resume continues the partial tick.
            end else if (start_ok) begin
                mode_q <= mode;
            end else if (state == RUN) begin
                prescaler <= wrap ? '0 : prescaler + 1'b1;
                if (wrap)
                    elapsed <= (mode_q == MODE_DOWN) ? elapsed - 1'b1 : elapsed + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear)
            lap_overflow <= 1'b0;
        else if (lap_push && lap_full && !lap_rd)
            lap_overflow <= 1'b1;
    end

    lap_fifo #(
        .WIDTH (TIME_W),
        .DEPTH (LAP_DEPTH)
    ) u_laps (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (lap_push),
        .pop   (lap_rd),
        .din   (elapsed),
        .head  (lap_time),
        .valid (lap_valid),
        .full  (lap_full),
        .count (lap_count)
    );

endmodule

// File: tb/tb_lap_timer.sv
// Directed plus randomized bench for lap_timer, compared each cycle against a tick-counting reference model.
module tb_lap_timer;

    localparam int CLK_DIV = 4;
    localparam int TIME_W  = 8;
    localparam int DEPTH   = 2;

    logic              clk = 1'b0;
    logic              rst, start, stop, clear, mode, load, lap, lap_rd;
    logic [TIME_W-1:0] load_value;
    logic [TIME_W-1:0] elapsed, lap_time;
    logic              running, tick, expired, lap_valid, lap_overflow;
    logic [1:0]        lap_count;

    int checks = 0;
    int errors = 0;
    int exp_seen = 0;

    // Reference model: run/pause/done flags, RUN cycles since last tick, lap queue.
    int m_el, m_frac;
    bit m_run, m_pause, m_done, m_down, m_ovf;
    int q[$];

    lap_timer #(.CLK_DIV(CLK_DIV), .TIME_W(TIME_W), .LAP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .load(load), .load_value(load_value), .lap(lap), .lap_rd(lap_rd),
        .elapsed(elapsed), .running(running), .tick(tick), .expired(expired),
        .lap_time(lap_time), .lap_valid(lap_valid), .lap_count(lap_count),
        .lap_overflow(lap_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic quiet();
        rst = 0; start = 0; stop = 0; clear = 0; load = 0; lap = 0; lap_rd = 0;
    endtask

    task automatic model_reset();
        m_el = 0; m_frac = 0; m_run = 0; m_pause = 0; m_done = 0; m_down = 0; m_ovf = 0;
        q.delete();
    endtask

    task automatic model_check();
        bit exp_tick;
        exp_tick = m_run && !rst && !clear && !load && !stop && (m_frac == CLK_DIV - 1);
        chk("elapsed", elapsed, m_el);
        chk("running", running, m_run);
        chk("tick", tick, exp_tick);
        chk("expired", expired, exp_tick && m_down && (m_el == 1));
        chk("lap_valid", lap_valid, q.size() > 0);
        chk("lap_count", lap_count, q.size());
        chk("lap_time", lap_time, (q.size() > 0) ? q[0] : 0);
        chk("lap_overflow", lap_overflow, m_ovf);
    endtask

    task automatic model_step();
        bit idle;
        idle = !m_run && !m_pause && !m_done;
        if (rst) begin
            model_reset();
            return;
        end
        if (clear) begin
            q.delete();
            m_ovf = 0;
        end else begin
            if (lap_rd && q.size() > 0) q.delete(0);
            if (lap && (m_run || m_pause)) begin
                if (q.size() < DEPTH) q.push_back(m_el);
                else m_ovf = 1;
            end
        end
        if (clear || load) begin
            m_el = clear ? 0 : int'(load_value);
            m_frac = 0; m_run = 0; m_pause = 0; m_done = 0;
        end else if (stop) begin
            if (m_run) begin m_run = 0; m_pause = 1; end
        end else if (start && (idle || m_pause) && !(mode && m_el == 0)) begin
            m_run = 1; m_pause = 0; m_down = mode;
        end else if (m_run) begin
            m_frac = (m_frac + 1) % CLK_DIV;
            if (m_frac == 0) begin
                if (m_down) begin
                    m_el = m_el - 1;
                    if (m_el == 0) begin m_run = 0; m_done = 1; end
                end else begin
                    m_el = (m_el + 1) % (1 << TIME_W);
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            model_check();
            if (expired === 1'b1) exp_seen++;
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        quiet();
        mode = 0; load_value = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cyc(1);
        rst = 0;
        chk("rst_elapsed", elapsed, 0);
        chk("rst_running", running, 0);
        chk("rst_lap_count", lap_count, 0);
        chk("rst_lap_time", lap_time, 0);

        // Up count and pause hold
        mode = 0; start = 1; cyc(1); start = 0;
        cyc(40);
        chk("up_elapsed_40", elapsed, 10);
        stop = 1; cyc(1); stop = 0;
        cyc(20);
        chk("pause_hold", elapsed, 10);

        // Pause keeps the sub-tick fraction
        clear = 1; cyc(1); clear = 0;
        start = 1; cyc(1); start = 0;
        cyc(6);
        chk("frac_elapsed1", elapsed, 1);
        stop = 1; cyc(10); stop = 0;
        start = 1; cyc(1); start = 0;
        cyc(1);
        chk("frac_before_tick", elapsed, 1);
        cyc(1);
        chk("frac_resume_tick", elapsed, 2);

        // Countdown to DONE
        load = 1; load_value = 3; cyc(1); load = 0;
        mode = 1; start = 1; cyc(1); start = 0;
        exp_seen = 0;
        cyc(12);
        chk("down_zero", elapsed, 0);
        chk("down_done_running", running, 0);
        chk("expired_once", exp_seen, 1);
        start = 1; cyc(1); start = 0;
        cyc(4);
        chk("done_ignores_start", running, 0);
        load = 1; load_value = 5; cyc(1); load = 0;
        start = 1; cyc(1); start = 0;
        cyc(4);
        chk("reload_count", elapsed, 4);

        // Up wrap without expiry
        load = 1; load_value = 255; cyc(1); load = 0;
        mode = 0; start = 1; cyc(1); start = 0;
        cyc(4);
        chk("wrap_zero", elapsed, 0);
        chk("wrap_no_expired", exp_seen, 1);

        // Laps with overflow and FWFT reads
        clear = 1; cyc(1); clear = 0;
        start = 1; cyc(1); start = 0;
        cyc(4);
        lap = 1; cyc(1); lap = 0;
        cyc(3);
        lap = 1; cyc(1); lap = 0;
        cyc(3);
        chk("lap3_elapsed", elapsed, 3);
        lap = 1; cyc(1); lap = 0;
        chk("lap_count_full", lap_count, 2);
        chk("lap_ovf_set", lap_overflow, 1);
        chk("lap_head1", lap_time, 1);
        stop = 1; cyc(1); stop = 0;
        lap_rd = 1; cyc(1); lap_rd = 0;
        chk("lap_head2", lap_time, 2);
        lap_rd = 1; cyc(1); lap_rd = 0;
        chk("lap_empty", lap_valid, 0);
        clear = 1; cyc(1); clear = 0;
        chk("lap_ovf_clear", lap_overflow, 0);

        // Priority corners
        start = 1; stop = 1; cyc(1); start = 0; stop = 0;
        chk("start_stop_idle", running, 0);
        load = 1; start = 1; load_value = 7; cyc(1); load = 0; start = 0;
        chk("load_start_run", running, 0);
        chk("load_start_val", elapsed, 7);
        mode = 1; start = 1; cyc(1); start = 0;
        cyc(6);
        chk("pre_rst_count", elapsed, 6);
        exp_seen = 0;
        rst = 1; cyc(1); rst = 0;
        chk("mid_rst_elapsed", elapsed, 0);
        chk("mid_rst_running", running, 0);
        cyc(8);
        chk("mid_rst_no_expired", exp_seen, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            clear  = ($urandom_range(0, 59) == 0);
            load   = ($urandom_range(0, 29) == 0);
            stop   = ($urandom_range(0, 11) == 0);
            start  = ($urandom_range(0, 5) == 0);
            mode   = $urandom_range(0, 1);
            lap    = ($urandom_range(0, 4) == 0);
            lap_rd = ($urandom_range(0, 4) == 0);
            load_value = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
            cyc(1);
        end
        quiet();
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lap_timer.md
Name: lap_timer

Overview:
Parametrised stopwatch/countdown timer for the piano's timing features (recording length, metronome/game countdowns). Divides the system clock into ticks with an exact period. Counts up (stopwatch) or down from a loaded value (timer), with pause/resume that keeps the sub-tick fraction. Captures lap times into a small FWFT buffer for the display/UI logic to read.

Parameters:
CLK_DIV, 100_000_000, clk cycles per tick (≥2); tick period is exactly CLK_DIV cycles
TIME_W, 32, width of time count in ticks
LAP_DEPTH, 4, lap buffer entries (≥1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  level/pulse; enter RUN
stop  in  1  level/pulse; enter PAUSE
clear  in  1  zero time, empty laps, go IDLE
mode  in  1  0 = count up, 1 = count down; sampled only outside RUN
load  in  1  load load_value into time
load_value  in  TIME_W  preset for countdown
lap  in  1  capture current time into lap buffer
lap_rd  in  1  pop lap buffer head
elapsed  out  TIME_W  current time in ticks
running  out  1  high in RUN
tick  out  1  1-cycle pulse on each elapsed update
expired  out  1  1-cycle pulse when countdown reaches 0
lap_time  out  TIME_W  lap buffer head (valid when lap_valid)
lap_valid  out  1  buffer non-empty
lap_count  out  $clog2(LAP_DEPTH+1)  entries held
lap_overflow  out  1  sticky: lap dropped because buffer full

Behaviour:
- Reset: state IDLE; prescaler, elapsed, lap_count, all output pulses, lap_overflow = 0; lap_time = 0; mode_q = 0.
- States: IDLE, RUN, PAUSE, DONE. Priority each cycle: rst > clear > load > stop > start.
- clear: elapsed=0, prescaler=0, buffer emptied, lap_overflow=0, → IDLE.
- load: elapsed=load_value, prescaler=0, → IDLE (also when in RUN).
- start in IDLE/PAUSE → RUN next cycle; mode_q<=mode latched. Ignored in DONE. Ignored in down mode if elapsed==0. start&stop same cycle: stop wins.
- stop in RUN → PAUSE; prescaler held (resume continues the fraction). stop elsewhere: no effect.
- RUN: prescaler increments; at CLK_DIV-1 wraps to 0, tick=1 same cycle the elapsed register updates (visible next cycle). First tick after IDLE start occurs exactly CLK_DIV cycles after the RUN entry.
- Up: elapsed+1, wraps 2^TIME_W-1 → 0 without flag.
- Down: elapsed-1; transition 1→0 pulses expired with tick, → DONE, running=0. DONE leaves only via load/clear/rst.
- Lap: lap in RUN or PAUSE pushes the current registered elapsed (pre-update value if tick coincides). Ignored in IDLE/DONE. Full and no pop: entry dropped, lap_overflow=1. Push+pop same cycle when full: both succeed. lap_rd when empty ignored. FWFT: lap_time shows head whenever lap_valid.
- rst/clear mid-run abort immediately; no expired pulse.

Decomposition:
- Package lap_timer_pkg: state enum (IDLE, RUN, PAUSE, DONE), MODE_UP/MODE_DOWN constants.
- Sub-module lap_fifo (parametrised width/depth, sync FWFT circular buffer with count, push/pop, clear); prescaler + FSM stay in lap_timer.

Test Plan (CLK_DIV=4, TIME_W=8, LAP_DEPTH=2):
- Up count: start 1 cycle → tick every 4 cycles; after 40 cycles of RUN elapsed=10; stop, idle 20 cycles, elapsed still 10.
- Pause fraction: run 6 cycles (elapsed=1, prescaler=2), stop 10 cycles, start → next tick after 2 RUN cycles, elapsed=2.
- Countdown: load 3, mode=1, start → ticks 2,1,0; expired pulses once with the 3rd tick; running=0, state DONE; further start ignored; load 5 then start resumes counting.
- Wrap: load 255, mode=0, start → after 4 cycles elapsed=0, no expired.
- Laps: laps at elapsed 1, 2, 3 → lap_count=2, lap_overflow=1, lap_time=1; lap_rd → lap_time=2; lap_rd → lap_valid=0; clear → lap_overflow=0.
- Priority: start&stop together in IDLE → stays IDLE; load&start together → IDLE with elapsed=load_value; rst mid-countdown → all outputs 0, no expired.
